// File: rtl/kb_irq_ctrl_if.sv
// Bus and interrupt-line bundle for kb_irq_ctrl.
// The slave modport is the controller's view; the master modport is the CPU/peripheral side.
interface kb_irq_ctrl_if #(
  parameter int NSRC = 8
);
  logic            cs_i;
  logic            we_i;
  logic [31:0]     adr_i;
  logic [31:0]     dat_i;
  logic [31:0]     dat_o;
  logic            ack_o;
  logic [NSRC-1:0] irq_i;
  logic            int_o;

  modport slave (
    input  cs_i,
    input  we_i,
    input  adr_i,
    input  dat_i,
    input  irq_i,
    output dat_o,
    output ack_o,
    output int_o
  );

  modport master (
    output cs_i,
    output we_i,
    output adr_i,
    output dat_i,
    output irq_i,
    input  dat_o,
    input  ack_o,
    input  int_o
  );
endinterface

// File: rtl/kb_irq_ctrl.sv
// Fixed-priority nesting interrupt controller: latches NSRC requests (edge or level),
// masks them, and drives one registered CPU interrupt with claim / end-of-interrupt over the bus.
module kb_irq_ctrl #(
  parameter int NSRC = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  kb_irq_ctrl_if.slave   bus
);

  localparam logic [5:0] LVL_NONE = 6'(NSRC);

  localparam logic [2:0] OFS_PEND  = 3'd0;
  localparam logic [2:0] OFS_EN    = 3'd1;
  localparam logic [2:0] OFS_MODE  = 3'd2;
  localparam logic [2:0] OFS_CLAIM = 3'd3;
  localparam logic [2:0] OFS_EOI   = 3'd4;
  localparam logic [2:0] OFS_ISR   = 3'd5;

  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_en;
  logic [NSRC-1:0] r_mode;
  logic [NSRC-1:0] r_isr;
  logic [NSRC-1:0] r_irq_prev;
  logic [31:0]     r_dat_o;
  logic            r_ack;
  logic            r_int;

  logic            w_start;
  logic            w_rd;
  logic            w_wr;
  logic [2:0]      w_ofs;
  logic [NSRC-1:0] w_pe;
  logic [5:0]      w_req;
  logic [5:0]      w_cur;
  logic            w_grant;
  logic            w_claim;
  logic [NSRC-1:0] w_req_oh;
  logic [NSRC-1:0] w_eoi_oh;
  logic [NSRC-1:0] w_w1c;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_pend_n;
  logic [NSRC-1:0] w_isr_n;
  logic [31:0]     w_rdata;

  // Index of the lowest set bit, or NSRC when the vector is empty.
  function automatic logic [5:0] f_lowest(input logic [NSRC-1:0] v);
    logic [5:0] r;
    r = LVL_NONE;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) r = 6'(i);
    end
    return r;
  endfunction

  assign w_start = bus.cs_i & ~r_ack;
  assign w_rd    = w_start & ~bus.we_i;
  assign w_wr    = w_start & bus.we_i;
  assign w_ofs   = bus.adr_i[4:2];

  assign w_pe    = r_pend & r_en;
  assign w_req   = f_lowest(w_pe);
  assign w_cur   = f_lowest(r_isr);
  assign w_grant = (|w_pe) && (w_req < w_cur);
  assign w_claim = w_rd && (w_ofs == OFS_CLAIM) && w_grant;

  always_comb begin
    w_req_oh = '0;
    w_eoi_oh = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_req_oh[i] = (w_req == 6'(i));
      w_eoi_oh[i] = w_wr && (w_ofs == OFS_EOI) && (bus.dat_i[4:0] == 5'(i));
    end
  end

  assign w_w1c = (w_wr && (w_ofs == OFS_PEND)) ? bus.dat_i[NSRC-1:0] : '0;
  assign w_clr = w_w1c | (w_claim ? w_req_oh : '0);

  // Edge bits: a fresh edge wins over a same-cycle clear. Level bits simply track irq_i.
  assign w_pend_n = (r_mode & ((bus.irq_i & ~r_irq_prev) | (r_pend & ~w_clr)))
                  | (~r_mode & bus.irq_i);

  assign w_isr_n = (r_isr & ~w_eoi_oh) | (w_claim ? w_req_oh : '0);

  always_comb begin
    w_rdata = '0;
    case (w_ofs)
      OFS_PEND:  w_rdata = 32'(r_pend);
      OFS_EN:    w_rdata = 32'(r_en);
      OFS_MODE:  w_rdata = 32'(r_mode);
      OFS_CLAIM: w_rdata = w_grant ? {26'b0, 1'b1, w_req[4:0]} : 32'b0;
      OFS_ISR:   w_rdata = 32'(r_isr);
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pend     <= '0;
      r_en       <= '0;
      r_mode     <= '0;
      r_isr      <= '0;
      r_irq_prev <= '0;
      r_dat_o    <= '0;
      r_ack      <= 1'b0;
      r_int      <= 1'b0;
    end else begin
      r_ack      <= w_start;
      r_dat_o    <= w_rd ? w_rdata : 32'b0;
      r_pend     <= w_pend_n;
      r_isr      <= w_isr_n;
      r_irq_prev <= bus.irq_i;
      r_int      <= w_grant;
      if (w_wr && (w_ofs == OFS_EN))   r_en   <= bus.dat_i[NSRC-1:0];
      if (w_wr && (w_ofs == OFS_MODE)) r_mode <= bus.dat_i[NSRC-1:0];
    end
  end

  assign bus.dat_o = r_dat_o;
  assign bus.ack_o = r_ack;
  assign bus.int_o = r_int;

endmodule

// File: tb/tb_kb_irq_ctrl.sv
// Directed bench for kb_irq_ctrl: bus reads push expected data into a queue that a
// negedge monitor pops whenever ack_o is seen; interrupt-line checks are made inline.
module tb_kb_irq_ctrl;

  localparam int NSRC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kb_irq_ctrl_if #(.NSRC(NSRC)) bif ();

  kb_irq_ctrl #(.NSRC(NSRC)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bif)
  );

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: one queue entry is consumed per acknowledged access.
  always @(negedge clk) begin
    if (bif.ack_o === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack with empty queue expected none");
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.chk) begin
          total++;
          if (bif.dat_o !== e.exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", e.nm, bif.dat_o, e.exp);
          end
        end
      end
    end
  end

  task automatic bus_irq(input logic we, input logic [2:0] ofs, input logic [31:0] wd,
                         input logic [31:0] exp, input logic [NSRC-1:0] irq_v, input string nm);
    exp_t e;
    @(negedge clk);
    bif.cs_i  = 1'b1;
    bif.we_i  = we;
    bif.adr_i = {27'b0, ofs, 2'b00};
    bif.dat_i = wd;
    bif.irq_i = irq_v;
    e.chk = ~we;
    e.exp = exp;
    e.nm  = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
    bif.cs_i = 1'b0;
    bif.we_i = 1'b0;
    check({nm, "_ack_hi"}, {31'b0, bif.ack_o}, 32'd1);
    @(posedge clk);
    #1;
    check({nm, "_ack_lo"}, {31'b0, bif.ack_o}, 32'd0);
  endtask

  task automatic rd(input logic [2:0] ofs, input logic [31:0] exp, input string nm);
    bus_irq(1'b0, ofs, 32'b0, exp, bif.irq_i, nm);
  endtask

  task automatic wr(input logic [2:0] ofs, input logic [31:0] wd);
    bus_irq(1'b1, ofs, wd, 32'b0, bif.irq_i, "wr");
  endtask

  // One-cycle pulse, then checks int_o stays low one cycle and rises the next.
  task automatic pulse(input logic [NSRC-1:0] v, input logic exp_late, input string nm);
    @(negedge clk);
    bif.irq_i = v;
    @(negedge clk);
    bif.irq_i = '0;
    check({nm, "_int_early"}, {31'b0, bif.int_o}, 32'd0);
    @(negedge clk);
    check({nm, "_int_late"}, {31'b0, bif.int_o}, {31'b0, exp_late});
  endtask

  task automatic int_is(input logic exp, input string nm);
    check(nm, {31'b0, bif.int_o}, {31'b0, exp});
  endtask

  initial begin
    bif.cs_i  = 1'b0;
    bif.we_i  = 1'b0;
    bif.adr_i = '0;
    bif.dat_i = '0;
    bif.irq_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset values
    for (int i = 0; i < 6; i++) rd(3'(i), 32'h0, $sformatf("rst_rd%0d", i));
    int_is(1'b0, "rst_int");

    // single edge source
    wr(3'd1, 32'h04);
    wr(3'd2, 32'h04);
    pulse(8'h04, 1'b1, "src2");
    rd(3'd0, 32'h04, "src2_pend");
    rd(3'd3, 32'h22, "src2_claim");
    int_is(1'b0, "src2_int_after_claim");
    rd(3'd0, 32'h00, "src2_pend_clr");
    rd(3'd5, 32'h04, "src2_isr");
    wr(3'd4, 32'h02);
    rd(3'd5, 32'h00, "src2_isr_eoi");

    // nesting
    wr(3'd1, 32'hFF);
    wr(3'd2, 32'hFF);
    pulse(8'h28, 1'b1, "src53");
    rd(3'd3, 32'h23, "claim3");
    int_is(1'b0, "int_src5_blocked");
    pulse(8'h02, 1'b1, "src1");
    rd(3'd3, 32'h21, "claim1_nested");
    rd(3'd5, 32'h0A, "isr_nested");
    int_is(1'b0, "int_after_nest");
    rd(3'd3, 32'h00, "claim_blocked");
    wr(3'd4, 32'h01);
    int_is(1'b0, "int_after_eoi1");
    wr(3'd4, 32'h03);
    int_is(1'b1, "int_after_eoi3");
    rd(3'd3, 32'h25, "claim5");
    wr(3'd4, 32'h05);
    wr(3'd4, 32'h1F);
    rd(3'd5, 32'h00, "isr_empty");

    // level mode
    wr(3'd2, 32'h00);
    wr(3'd1, 32'h01);
    @(negedge clk);
    bif.irq_i = 8'h01;
    @(negedge clk);
    @(negedge clk);
    int_is(1'b1, "lvl_int");
    rd(3'd3, 32'h20, "lvl_claim");
    wr(3'd0, 32'h01);
    rd(3'd0, 32'h01, "lvl_pend_w1c_ignored");
    int_is(1'b0, "lvl_int_in_service");
    wr(3'd4, 32'h00);
    int_is(1'b1, "lvl_int_after_eoi");
    @(negedge clk);
    bif.irq_i = '0;
    @(negedge clk);
    @(negedge clk);
    int_is(1'b0, "lvl_int_dropped");
    rd(3'd0, 32'h00, "lvl_pend_dropped");

    // set wins over same-cycle W1C, masked source
    wr(3'd2, 32'h10);
    wr(3'd1, 32'h00);
    rd(3'd2, 32'h10, "mode_rb");
    bus_irq(1'b1, 3'd0, 32'h10, 32'h0, 8'h10, "w1c_edge");
    bif.irq_i = '0;
    rd(3'd0, 32'h10, "set_wins");
    int_is(1'b0, "masked_int");
    rd(3'd3, 32'h00, "masked_claim");
    wr(3'd0, 32'h10);
    rd(3'd0, 32'h00, "w1c_clears");
    rd(3'd6, 32'h00, "rd_ofs6");

    // async reset mid-access
    wr(3'd1, 32'h10);
    pulse(8'h10, 1'b1, "src4");
    rd(3'd3, 32'h24, "claim4");
    pulse(8'h10, 1'b0, "src4b");
    rd(3'd0, 32'h10, "pre_rst_pend");
    @(negedge clk);
    bif.cs_i  = 1'b1;
    bif.we_i  = 1'b0;
    bif.adr_i = 32'h0;
    @(posedge clk);
    #2;
    check("pre_rst_ack", {31'b0, bif.ack_o}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_ack", {31'b0, bif.ack_o}, 32'd0);
    check("arst_dat", bif.dat_o, 32'h0);
    check("arst_int", {31'b0, bif.int_o}, 32'd0);
    bif.cs_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(3'd0, 32'h00, "post_rst_pend");
    rd(3'd1, 32'h00, "post_rst_en");
    rd(3'd2, 32'h00, "post_rst_mode");
    rd(3'd5, 32'h00, "post_rst_isr");

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
